// File: rtl/mine_pkg.sv
// Shared types for the mining job sequencer: FSM state encoding and result status codes.
package mine_pkg;

  localparam int NONCE_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOAD   = 2'b01,
    MINE   = 2'b10,
    REPORT = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    ST_NONE    = 2'b00,
    ST_FOUND   = 2'b01,
    ST_EXHAUST = 2'b10,
    ST_STALL   = 2'b11
  } status_t;

endpackage

// File: rtl/nonce_monitor.sv
// Tracks the miner's nonce cycle to cycle and flags a wrap to zero or a nonce that has stopped moving.
module nonce_monitor
  import mine_pkg::*;
#(
  parameter int NONCE_W     = NONCE_W_DEF,
  parameter int STALL_LIMIT = 1024
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load_i,
  input  logic [NONCE_W-1:0] load_val_i,
  input  logic               track_i,
  input  logic [NONCE_W-1:0] miner_nonce_i,
  output logic [NONCE_W-1:0] prev_nonce_o,
  output logic               wrap_o,
  output logic               stall_o
);

  localparam int CW = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STALL_LIMIT - 1);

  logic [NONCE_W-1:0] prev_q, prev_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               changed;

  assign changed = (miner_nonce_i != prev_q);

  // The count stops at CNT_MAX; the stall flag fires there, so the counter never overflows.
  always_comb begin
    prev_d = prev_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      prev_d = load_val_i;
      cnt_d  = '0;
    end else if (track_i) begin
      prev_d = miner_nonce_i;
      if (changed) begin
        cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q <= '0;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

  assign prev_nonce_o = prev_q;
  assign wrap_o       = track_i && (&prev_q) && (miner_nonce_i == '0);
  assign stall_o      = track_i && !changed && (cnt_q == CNT_MAX);

endmodule

// File: rtl/mine_job_sequencer.sv
// Runs one mining job: latch header, pulse miner reset, watch progress, report nonce and status.
// Handshakes: a transfer happens on a posedge where valid and ready are both high; tx_valid holds until taken.
module mine_job_sequencer
  import mine_pkg::*;
#(
  parameter int HDR_W       = 640,
  parameter int NONCE_W     = NONCE_W_DEF,
  parameter int RST_CYCLES  = 4,
  parameter int STALL_LIMIT = 1024
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               hdr_valid,
  input  logic [HDR_W-1:0]   hdr_in,
  output logic               hdr_ready,
  output logic [HDR_W-1:0]   miner_header,
  output logic               miner_reset,
  input  logic [NONCE_W-1:0] miner_nonce,
  input  logic               miner_found,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [NONCE_W-1:0] tx_nonce,
  output logic [1:0]         tx_status,
  output logic               busy,
  output logic               found_led,
  output logic [1:0]         dbg_state
);

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);

  state_t             state_q;
  logic [HDR_W-1:0]   miner_header_q;
  logic               miner_reset_q;
  logic               hdr_ready_q;
  logic               tx_valid_q;
  logic [NONCE_W-1:0] tx_nonce_q;
  status_t            tx_status_q;
  logic               busy_q;
  logic               found_led_q;
  logic [RCW-1:0]     rst_cnt_q;

  logic               hdr_fire;
  logic [NONCE_W-1:0] prev_nonce;
  logic               wrap;
  logic               stall;
  logic               ev_hit;
  logic [NONCE_W-1:0] ev_nonce;
  status_t            ev_status;

  assign hdr_fire = hdr_valid && hdr_ready_q;

  nonce_monitor #(
    .NONCE_W     (NONCE_W),
    .STALL_LIMIT (STALL_LIMIT)
  ) u_monitor (
    .clock         (clock),
    .reset         (reset),
    .load_i        (hdr_fire),
    .load_val_i    (hdr_in[NONCE_W-1:0]),
    .track_i       (state_q == MINE),
    .miner_nonce_i (miner_nonce),
    .prev_nonce_o  (prev_nonce),
    .wrap_o        (wrap),
    .stall_o       (stall)
  );

  // Found beats wrap beats stall; wrap reports the last nonce before it rolled over.
  always_comb begin
    ev_hit    = 1'b0;
    ev_nonce  = miner_nonce;
    ev_status = ST_FOUND;
    if (miner_found) begin
      ev_hit = 1'b1;
    end else if (wrap) begin
      ev_hit    = 1'b1;
      ev_nonce  = prev_nonce;
      ev_status = ST_EXHAUST;
    end else if (stall) begin
      ev_hit    = 1'b1;
      ev_status = ST_STALL;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      miner_header_q <= '0;
      miner_reset_q  <= 1'b1;
      hdr_ready_q    <= 1'b0;
      tx_valid_q     <= 1'b0;
      tx_nonce_q     <= '0;
      tx_status_q    <= ST_NONE;
      busy_q         <= 1'b0;
      found_led_q    <= 1'b0;
      rst_cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          hdr_ready_q   <= 1'b1;
          miner_reset_q <= 1'b1;
          if (hdr_fire) begin
            miner_header_q <= hdr_in;
            hdr_ready_q    <= 1'b0;
            busy_q         <= 1'b1;
            rst_cnt_q      <= '0;
            state_q        <= LOAD;
          end
        end
        LOAD: begin
          if (rst_cnt_q == RST_LAST) begin
            miner_reset_q <= 1'b0;
            hdr_ready_q   <= 1'b1;
            state_q       <= MINE;
          end else begin
            rst_cnt_q <= rst_cnt_q + 1'b1;
          end
        end
        MINE: begin
          if (hdr_fire) begin
            miner_header_q <= hdr_in;
            miner_reset_q  <= 1'b1;
            hdr_ready_q    <= 1'b0;
            rst_cnt_q      <= '0;
            state_q        <= LOAD;
          end else if (ev_hit) begin
            tx_nonce_q    <= ev_nonce;
            tx_status_q   <= ev_status;
            tx_valid_q    <= 1'b1;
            miner_reset_q <= 1'b1;
            hdr_ready_q   <= 1'b0;
            if (ev_status == ST_FOUND) begin
              found_led_q <= 1'b1;
            end
            state_q <= REPORT;
          end
        end
        REPORT: begin
          if (tx_ready) begin
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            hdr_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign miner_header = miner_header_q;
  assign miner_reset  = miner_reset_q;
  assign hdr_ready    = hdr_ready_q;
  assign tx_valid     = tx_valid_q;
  assign tx_nonce     = tx_nonce_q;
  assign tx_status    = tx_status_q;
  assign busy         = busy_q;
  assign found_led    = found_led_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mine_job_sequencer.sv
// Bench for mine_job_sequencer: scripted jobs drive the miner side, a scoreboard checks each reported result.
module tb_mine_job_sequencer;
  import mine_pkg::*;

  localparam int HW   = 640;
  localparam int NW   = 32;
  localparam int RSTC = 4;
  localparam int STL  = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          hdr_valid = 1'b0;
  logic [HW-1:0] hdr_in = '0;
  logic          hdr_ready;
  logic [HW-1:0] miner_header;
  logic          miner_reset;
  logic [NW-1:0] miner_nonce = '0;
  logic          miner_found = 1'b0;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic [NW-1:0] tx_nonce;
  logic [1:0]    tx_status;
  logic          busy;
  logic          found_led;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [NW+1:0] exp_q[$];

  mine_job_sequencer #(
    .HDR_W       (HW),
    .NONCE_W     (NW),
    .RST_CYCLES  (RSTC),
    .STALL_LIMIT (STL)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .hdr_valid    (hdr_valid),
    .hdr_in       (hdr_in),
    .hdr_ready    (hdr_ready),
    .miner_header (miner_header),
    .miner_reset  (miner_reset),
    .miner_nonce  (miner_nonce),
    .miner_found  (miner_found),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_nonce     (tx_nonce),
    .tx_status    (tx_status),
    .busy         (busy),
    .found_led    (found_led),
    .dbg_state    (dbg_state)
  );

  // Clock and watchdog
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [HW-1:0] got, input logic [HW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted result must match the oldest expectation.
  always @(negedge clock) begin
    if (!reset && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        check("tx_unexpected", HW'(1), HW'(0));
      end else begin
        logic [NW+1:0] e;
        e = exp_q.pop_front();
        check("sb_nonce", HW'(tx_nonce), HW'(e[NW-1:0]));
        check("sb_status", HW'(tx_status), HW'(e[NW+1:NW]));
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic step(input logic [NW-1:0] nonce, input logic found);
    miner_nonce = nonce;
    miner_found = found;
    tick();
  endtask

  function automatic logic [HW-1:0] rand_header(input logic [NW-1:0] nonce);
    logic [HW-1:0] r;
    for (int i = 0; i < HW / 32; i++) r[i*32 +: 32] = $urandom;
    r[NW-1:0] = nonce;
    return r;
  endfunction

  task automatic send_header(input logic [HW-1:0] hdr);
    int k = 0;
    hdr_in    = hdr;
    hdr_valid = 1'b1;
    while (!hdr_ready && k < 20) begin
      tick();
      k++;
    end
    check("hdr_ready_seen", HW'(hdr_ready), HW'(1));
    tick();
    hdr_valid = 1'b0;
    check("hdr_reg", miner_header, hdr);
    check("load_reset", HW'(miner_reset), HW'(1));
    check("load_busy", HW'(busy), HW'(1));
  endtask

  task automatic load_phase(input logic [HW-1:0] hdr);
    int k = 0;
    miner_nonce = hdr[NW-1:0];
    while (miner_reset && k < 20) begin
      tick();
      k++;
    end
    check("reset_len", HW'(k), HW'(RSTC));
    check("mine_hdr_ready", HW'(hdr_ready), HW'(1));
  endtask

  task automatic start_job(input logic [HW-1:0] hdr);
    send_header(hdr);
    load_phase(hdr);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (dbg_state != IDLE && k < 40) begin
      tick();
      k++;
    end
    check("idle_state", HW'(dbg_state), HW'(IDLE));
    check("idle_tx_valid", HW'(tx_valid), HW'(0));
    check("idle_busy", HW'(busy), HW'(0));
  endtask

  task automatic run_found(input logic [HW-1:0] hdr, input int steps);
    logic [NW-1:0] n;
    n = hdr[NW-1:0];
    start_job(hdr);
    for (int i = 0; i < steps; i++) step(n + NW'(i), 1'b0);
    exp_q.push_back({ST_FOUND, n + NW'(steps)});
    step(n + NW'(steps), 1'b1);
    miner_found = 1'b0;
    check("found_valid", HW'(tx_valid), HW'(1));
    check("found_led", HW'(found_led), HW'(1));
    wait_idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hdr_ready"}, HW'(hdr_ready), HW'(0));
    check({tag, "_miner_reset"}, HW'(miner_reset), HW'(1));
    check({tag, "_tx_valid"}, HW'(tx_valid), HW'(0));
    check({tag, "_tx_nonce"}, HW'(tx_nonce), HW'(0));
    check({tag, "_tx_status"}, HW'(tx_status), HW'(0));
    check({tag, "_miner_header"}, miner_header, HW'(0));
    check({tag, "_busy"}, HW'(busy), HW'(0));
    check({tag, "_found_led"}, HW'(found_led), HW'(0));
  endtask

  initial begin
    logic [HW-1:0] h;
    logic [HW-1:0] h2;
    int k;

    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    check_reset_outputs("por");
    reset = 1'b0;
    tick();
    check("idle_hdr_ready", HW'(hdr_ready), HW'(1));

    // Found outside MINE is ignored
    miner_found = 1'b1;
    repeat (3) tick();
    check("idle_found_ignored", HW'(tx_valid), HW'(0));
    check("idle_found_led", HW'(found_led), HW'(0));
    miner_found = 1'b0;

    // Directed found job: header nonce 0x42a14694, found at 0x42a14695
    run_found(rand_header(32'h42a1_4694), 1);
    check("led_sticky", HW'(found_led), HW'(1));

    // Randomised found jobs
    for (int j = 0; j < 4; j++) run_found(rand_header($urandom), $urandom_range(1, 5));

    // Nonce wrap reports the all-ones nonce as exhausted
    h = rand_header(32'hFFFF_FFFE);
    start_job(h);
    step(32'hFFFF_FFFE, 1'b0);
    step(32'hFFFF_FFFF, 1'b0);
    exp_q.push_back({ST_EXHAUST, 32'hFFFF_FFFF});
    step(32'h0000_0000, 1'b0);
    check("wrap_valid", HW'(tx_valid), HW'(1));
    check("wrap_status", HW'(tx_status), HW'(2'b10));
    wait_idle();

    // Found and wrap together: found wins with the current nonce
    start_job(h);
    step(32'hFFFF_FFFE, 1'b0);
    step(32'hFFFF_FFFF, 1'b0);
    exp_q.push_back({ST_FOUND, 32'h0000_0000});
    step(32'h0000_0000, 1'b1);
    miner_found = 1'b0;
    check("tie_status", HW'(tx_status), HW'(2'b01));
    wait_idle();

    // Frozen nonce: stall reported eight cycles after the last change
    h = rand_header(32'h1234_5670);
    start_job(h);
    exp_q.push_back({ST_STALL, 32'h1234_5671});
    miner_nonce = 32'h1234_5671;
    k = 0;
    while (!tx_valid && k < 40) begin
      tick();
      k++;
    end
    check("stall_latency", HW'(k), HW'(9));
    check("stall_status", HW'(tx_status), HW'(2'b11));
    wait_idle();

    // Back-pressure: result held stable while tx_ready is low
    tx_ready = 1'b0;
    h = rand_header(32'h0BAD_F00D);
    start_job(h);
    step(32'h0BAD_F00D, 1'b0);
    exp_q.push_back({ST_FOUND, 32'h0BAD_F00E});
    step(32'h0BAD_F00E, 1'b1);
    miner_found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      miner_nonce = $urandom;
      check("hold_valid", HW'(tx_valid), HW'(1));
      check("hold_nonce", HW'(tx_nonce), HW'(32'h0BAD_F00E));
      check("hold_status", HW'(tx_status), HW'(2'b01));
      tick();
    end
    tx_ready = 1'b1;
    tick();
    check("release_state", HW'(dbg_state), HW'(IDLE));
    check("release_valid", HW'(tx_valid), HW'(0));
    check("release_hdr_ready", HW'(hdr_ready), HW'(1));

    // New header mid-MINE aborts the job, even alongside a found pulse
    h  = rand_header(32'h5555_0000);
    h2 = rand_header(32'hAAAA_0000);
    start_job(h);
    step(32'h5555_0000, 1'b0);
    step(32'h5555_0001, 1'b0);
    miner_found = 1'b1;
    send_header(h2);
    miner_found = 1'b0;
    check("abort_no_valid", HW'(tx_valid), HW'(0));
    load_phase(h2);
    check("abort_no_valid2", HW'(tx_valid), HW'(0));
    step(32'hAAAA_0000, 1'b0);
    exp_q.push_back({ST_FOUND, 32'hAAAA_0001});
    step(32'hAAAA_0001, 1'b1);
    miner_found = 1'b0;
    wait_idle();

    // Reset while in REPORT
    tx_ready = 1'b0;
    h = rand_header(32'h0000_1000);
    start_job(h);
    step(32'h0000_1000, 1'b0);
    step(32'h0000_1001, 1'b1);
    miner_found = 1'b0;
    check("pre_reset_valid", HW'(tx_valid), HW'(1));
    reset = 1'b1;
    tick();
    check_reset_outputs("rst_report");
    reset = 1'b0;
    tx_ready = 1'b1;
    tick();

    // Reset while in LOAD
    send_header(rand_header($urandom));
    tick();
    reset = 1'b1;
    tick();
    check_reset_outputs("rst_load");
    reset = 1'b0;
    repeat (2) tick();

    check("queue_drained", HW'(exp_q.size()), HW'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
